// File: rtl/gcd_pkg.sv
// Shared types and default timing for the GCD processor host driver.
package gcd_pkg;

  localparam int unsigned W_DEF         = 8;
  localparam int unsigned SETUP_CYC_DEF = 5;
  localparam int unsigned ENTER_CYC_DEF = 2;
  localparam int unsigned GAP_CYC_DEF   = 5;
  localparam int unsigned PRST_CYC_DEF  = 1;
  localparam int unsigned TIMEOUT_DEF   = 1024;

  typedef enum logic [3:0] {
    INIT, IDLE, PRST, SETUP_A, ENTER_A, GAP, SETUP_B, ENTER_B, WAIT_HALT, DONE
  } state_t;

  function automatic int unsigned max2(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/gcd_host_driver.sv
// Operator-side sequencer for one GCD processor: init, reset, enter A/B, wait Halt, return Output.
module gcd_host_driver
  import gcd_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
  parameter int unsigned ENTER_CYC = ENTER_CYC_DEF,
  parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
  parameter int unsigned PRST_CYC  = PRST_CYC_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic         Error,
  output logic         ProcEnable,
  output logic         ProcReset,
  output logic         ProcEnter,
  output logic [W-1:0] ProcInput,
  input  logic         ProcHalt,
  input  logic [W-1:0] ProcOutput
);

  localparam int unsigned MAXC = max2(max2(max2(SETUP_CYC, ENTER_CYC), max2(GAP_CYC, PRST_CYC)), TIMEOUT);
  localparam int unsigned CW   = $clog2(MAXC + 1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [W-1:0]   a_reg, b_reg;

  function automatic logic [CW-1:0] load(input state_t s);
    case (s)
      PRST:             return CW'(PRST_CYC - 1);
      SETUP_A, SETUP_B: return CW'(SETUP_CYC - 1);
      ENTER_A, ENTER_B: return CW'(ENTER_CYC - 1);
      GAP:              return CW'(GAP_CYC - 1);
      WAIT_HALT:        return CW'(TIMEOUT - 1);
      default:          return '0;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = (cnt != '0) ? cnt - 1'b1 : cnt;
    case (state)
      // First INIT cycle mirrors reset outputs; cnt=1 marks the single enable cycle.
      INIT:      if (cnt == '0) cnt_next = CW'(1);
                 else           state_next = IDLE;
      IDLE:      if (Start) state_next = (A != '0 && B != '0) ? PRST : DONE;
      PRST:      if (cnt == '0) state_next = SETUP_A;
      SETUP_A:   if (cnt == '0) state_next = ENTER_A;
      ENTER_A:   if (cnt == '0) state_next = GAP;
      GAP:       if (cnt == '0) state_next = SETUP_B;
      SETUP_B:   if (cnt == '0) state_next = ENTER_B;
      ENTER_B:   if (cnt == '0) state_next = WAIT_HALT;
      WAIT_HALT: if (ProcHalt || cnt == '0) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = INIT;
    endcase
    if (state_next != state) cnt_next = load(state_next);
  end

  always_comb begin
    Busy       = !(state == INIT || state == IDLE);
    Done       = (state == DONE);
    ProcEnable = (state == INIT) && (cnt != '0);
    ProcReset  = (state == INIT) || (state == PRST);
    ProcEnter  = (state == ENTER_A) || (state == ENTER_B);
    case (state)
      SETUP_A, ENTER_A:                    ProcInput = a_reg;
      GAP, SETUP_B, ENTER_B, WAIT_HALT:    ProcInput = b_reg;
      default:                             ProcInput = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= INIT;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      Result <= '0;
      Error  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && Start) begin
        a_reg <= A;
        b_reg <= B;
        if (A == '0 || B == '0) begin
          Result <= '0;
          Error  <= 1'b1;
        end
      end
      if (state == WAIT_HALT) begin
        if (ProcHalt) begin
          Result <= ProcOutput;
          Error  <= 1'b0;
        end else if (cnt == '0) begin
          Result <= '0;
          Error  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_host_driver.sv
// Scoreboard bench: driver plus a behavioural GCD processor; second driver faces a silent processor.
module tb_gcd_host_driver;

  localparam int unsigned W        = 8;
  localparam int unsigned SETUP    = 5;
  localparam int unsigned ENT      = 2;
  localparam int unsigned GAPC     = 5;
  localparam int unsigned PRS      = 1;
  localparam int unsigned TO_SHORT = 16;
  localparam int unsigned HALT_LAT = 3;
  // Model raises Halt HALT_LAT+1 cycles after Enter falls; the driver sees it one cycle later.
  localparam int unsigned HALT_WAIT = HALT_LAT + 2;
  localparam int unsigned NOMINAL   = PRS + 2*SETUP + 2*ENT + GAPC + HALT_WAIT + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start_t;
  logic [W-1:0] a, b;
  logic busy, done, error, p_en, p_rst, p_enter, p_halt;
  logic [W-1:0] result, p_in, p_out;
  logic busy_t, done_t, error_t, en_t, rst_t, enter_t;
  logic [W-1:0] result_t, in_t;

  gcd_host_driver #(.W(W), .SETUP_CYC(SETUP), .ENTER_CYC(ENT), .GAP_CYC(GAPC),
                    .PRST_CYC(PRS), .TIMEOUT(1024)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .A(a), .B(b),
    .Busy(busy), .Done(done), .Result(result), .Error(error),
    .ProcEnable(p_en), .ProcReset(p_rst), .ProcEnter(p_enter), .ProcInput(p_in),
    .ProcHalt(p_halt), .ProcOutput(p_out));

  gcd_host_driver #(.W(W), .SETUP_CYC(SETUP), .ENTER_CYC(ENT), .GAP_CYC(GAPC),
                    .PRST_CYC(PRS), .TIMEOUT(TO_SHORT)) dut_to (
    .Clock(clk), .Reset(rst_n), .Start(start_t), .A(a), .B(b),
    .Busy(busy_t), .Done(done_t), .Result(result_t), .Error(error_t),
    .ProcEnable(en_t), .ProcReset(rst_t), .ProcEnter(enter_t), .ProcInput(in_t),
    .ProcHalt(1'b0), .ProcOutput(8'h5A));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  function automatic logic [W-1:0] proc_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == '0 || y == '0) return x | y;
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return x;
  endfunction

  // Behavioural processor: captures Input on each Enter rise, halts after the second pulse.
  logic [W-1:0] pa, pb;
  int unsigned  pphase, hcnt;
  logic         enter_q;
  always @(posedge clk) begin
    if (p_rst) begin
      pphase <= 0; hcnt <= 0; enter_q <= 1'b0; p_halt <= 1'b0; p_out <= '0;
    end else begin
      enter_q <= p_enter;
      if (p_enter && !enter_q) begin
        if (pphase == 0) pa <= p_in;
        else             pb <= p_in;
        pphase <= pphase + 1;
      end
      if (!p_enter && enter_q && pphase == 2) hcnt <= HALT_LAT;
      else if (hcnt > 1) hcnt <= hcnt - 1;
      else if (hcnt == 1) begin
        hcnt <= 0; p_halt <= 1'b1; p_out <= proc_gcd(pa, pb);
      end
    end
  end

  typedef struct { logic [W-1:0] res; logic err; } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] op_q[$];

  logic         in_pulse = 1'b0;
  logic         en_q = 1'b0;
  int           pulse_len = 0;
  int           en_rises = 0;
  logic [W-1:0] pulse_val = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_pulse = 1'b0;
      pulse_len = 0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) check("unexpected done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("error", error, e.err);
        end
        check("busy at done", busy, 1);
      end
      if (p_enter) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          pulse_len = 0;
          if (op_q.size() == 0) begin
            check("unexpected enter", 1, 0);
            pulse_val = p_in;
          end else begin
            pulse_val = op_q.pop_front();
            check("enter operand", p_in, pulse_val);
          end
        end else check("input stable in enter", p_in, pulse_val);
        pulse_len++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        check("enter width", pulse_len, ENT);
      end
      if (p_en && !en_q) en_rises++;
      en_q = p_en;
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    a = av; b = bv;
    if (av == '0 || bv == '0) begin
      e.res = '0; e.err = 1'b1;
    end else begin
      e.res = ref_gcd(int'(av), int'(bv)); e.err = 1'b0;
      op_q.push_back(av);
      op_q.push_back(bv);
    end
    exp_q.push_back(e);
  endtask

  task automatic run_job(input logic [W-1:0] av, input logic [W-1:0] bv);
    int cyc, drops;
    @(posedge clk); #1;
    issue(av, bv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; drops = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!busy) drops++;
    end while (!done && cyc < 3000);
    check("job completes", done, 1);
    check("busy throughout job", drops, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, k, falls, rises, nz;
    logic prev;
    rst_n = 1'b0; start = 1'b0; start_t = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset error", error, 0);
    check("reset enable", p_en, 0);
    check("reset procreset", p_rst, 1);
    check("reset enter", p_enter, 0);
    check("reset input", p_in, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    run_job(8'd48, 8'd18);
    check("two enter pulses consumed", op_q.size(), 0);

    for (int i = 0; i < 9; i++)
      run_job(W'($urandom_range(1, 127)), W'($urandom_range(1, 9)));

    // Zero operand: immediate error, processor pins untouched.
    @(posedge clk); #1;
    issue(8'd0, 8'd5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero op done latency", done, 1);
    nz = 0;
    repeat (6) begin
      if (p_rst || p_enter || p_en) nz++;
      @(negedge clk);
    end
    check("zero op pins quiet", nz, 0);

    // Silent processor: timeout after TO_SHORT cycles of WAIT_HALT.
    @(posedge clk); #1;
    a = 8'd3; b = 8'd7; start_t = 1'b1;
    @(posedge clk); #1;
    start_t = 1'b0;
    prev = 1'b0; falls = 0; n = 0;
    while (falls < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (enter_t) check("timeout unit enter input", in_t, (falls == 0) ? 3 : 7);
      if (prev && !enter_t) falls++;
      prev = enter_t;
    end
    check("timeout unit reached wait", falls, 2);
    k = 0;
    while (!done_t && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout latency", k, TO_SHORT);
    check("timeout error", error_t, 1);
    check("timeout result", result_t, 0);
    check("timeout busy at done", busy_t, 1);
    check("timeout pins idle", {en_t, rst_t, enter_t}, 0);

    // Start held high: three back-to-back jobs.
    @(posedge clk); #1;
    repeat (3) issue(8'd12, 8'd8);
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 3000);
      if (j == 2) start = 1'b0;
      if (j > 0) check("back-to-back spacing", n, NOMINAL);
    end
    repeat (3) @(negedge clk);
    check("back-to-back all returned", exp_q.size(), 0);

    // Reset during ENTER_B aborts the job with no Done.
    @(posedge clk); #1;
    a = 8'd48; b = 8'd18;
    op_q.push_back(8'd48);
    op_q.push_back(8'd18);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = 1'b0; rises = 0; n = 0;
    while (rises < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (p_enter && !prev) rises++;
      prev = p_enter;
    end
    check("reached enter b", rises, 2);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort enable", p_en, 0);
    check("abort procreset", p_rst, 1);
    check("abort enter", p_enter, 0);
    check("abort input", p_in, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    run_job(8'd35, 8'd14);

    repeat (4) @(negedge clk);
    check("enable pulses", en_rises, 2);
    check("scoreboard empty", exp_q.size(), 0);
    check("operand queue empty", op_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_host_driver.md
Name: gcd_host_driver

Overview:
Hardware counterpart of the GCD Processor's operator-side interface. It accepts an operand pair on a start/done handshake and owns the processor's Enable, Reset, Enter and Input pins. It initialises the processor memory, resets the processor, enters operand A and then operand B with the required setup and Enter-pulse timing, and waits for Halt. It then captures Output and returns it upstream. It sits between a host/controller and one Processor instance and replaces bench-driven stimulus in system builds.

Parameters:
W, 8, operand/result width
SETUP_CYC, 5, cycles Input is held stable before Enter rises (>=1)
ENTER_CYC, 2, cycles Enter is held high (>=1)
GAP_CYC, 5, cycles Enter is held low between operand A and operand B (>=1)
PRST_CYC, 1, cycles ProcReset is held high before each job (>=1)
TIMEOUT, 1024, max WAIT_HALT cycles before abort (>=2)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  job request; sampled only in IDLE
A  in  W  operand A; captured when Start is accepted
B  in  W  operand B; captured when Start is accepted
Busy  out  1  high from Start acceptance until Done
Done  out  1  one-cycle pulse at job end
Result  out  W  GCD result; valid from Done until next accept
Error  out  1  valid with Done: 1 = zero operand or timeout
ProcEnable  out  1  processor memory-init strobe
ProcReset  out  1  processor reset, active-high
ProcEnter  out  1  processor Enter
ProcInput  out  W  processor Input bus
ProcHalt  in  1  processor Halt
ProcOutput  in  W  processor Output bus

Behaviour:
- Reset (async assert, sync release): state=INIT; Busy=0, Done=0, Result=0, Error=0, ProcEnable=0, ProcReset=1, ProcEnter=0, ProcInput=0; counters=0.
- INIT: ProcEnable=1 and ProcReset=1 for exactly 1 cycle, then go to IDLE. This happens once per reset only.
- IDLE: ProcReset=0, Busy=0.
  - Start=1 with A!=0 and B!=0: latch A and B, Busy=1, go to PRST.
  - Start=1 with A==0 or B==0: no processor activity. Next cycle Done=1, Error=1, Result=0, return to IDLE.
- PRST: ProcReset=1 for PRST_CYC cycles -> SETUP_A.
- SETUP_A: ProcInput=A_reg for SETUP_CYC cycles -> ENTER_A.
- ENTER_A: ProcEnter=1 for ENTER_CYC cycles -> GAP.
- GAP: ProcEnter=0 for GAP_CYC cycles; ProcInput switches to B_reg on GAP entry -> SETUP_B.
- SETUP_B: ProcInput=B_reg for SETUP_CYC cycles -> ENTER_B.
- ENTER_B: ProcEnter=1 for ENTER_CYC cycles -> WAIT_HALT.
- ProcInput is held constant throughout every Enter-high window.
- WAIT_HALT: ProcEnter=0; timeout counter starts at 0.
  - ProcHalt=1 sampled: Result<=ProcOutput, Error<=0 -> DONE.
  - Counter reaches TIMEOUT-1 with no Halt: Result<=0, Error<=1 -> DONE.
  - Halt that arrives in any state before WAIT_HALT is ignored.
- DONE: Done=1 for 1 cycle, Busy=0 on the following cycle, go to IDLE. Result and Error hold until the next accept.
- Start is ignored while Busy. A back-to-back Start in the cycle after Done is accepted.
- Reset mid-job: immediate abort to reset values and a fresh INIT. No Done is issued for the aborted job.
- Nominal latency, Start accept to Done: PRST_CYC + 2*SETUP_CYC + 2*ENTER_CYC + GAP_CYC + halt_wait + 2.
- One shared down-counter is wide enough for max(TIMEOUT, all phase counts); it reloads on every state entry.

Decomposition:
- Shared package gcd_pkg: state enum (INIT, IDLE, PRST, SETUP_A, ENTER_A, GAP, SETUP_B, ENTER_B, WAIT_HALT, DONE), default timing constants, and the W default.
- No sub-module is needed; the block is a single FSM plus phase counter.
- The bench instantiates gcd_host_driver together with the real Processor.

Test Plan:
- A=48, B=18, real Processor -> one Done, Result=6, Error=0. ProcEnter pulses exactly twice, each ENTER_CYC long. ProcInput=48 during the first pulse and 18 during the second.
- Loop 9 jobs: A=random 1..127, B=1..9 -> each Result equals a software GCD. No Done while Busy=0. Busy high throughout each job.
- A=0, B=5 -> Done 1 cycle after Start, Error=1, Result=0. ProcReset, ProcEnter and ProcEnable never toggle.
- Processor replaced by a stub that holds Halt=0, TIMEOUT=16 -> Done exactly 16 cycles after WAIT_HALT entry, Error=1, Result=0.
- Assert Reset low during ENTER_B -> all outputs return to reset values asynchronously. After release, ProcEnable pulses once, no Done is issued, and a following A=35, B=14 job returns 7.
- Start held high continuously with A=12, B=8 -> jobs run back-to-back, each Result=4, Done pulses separated by the full nominal latency.
